// File: rtl/change_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : change_update_ctrl
// Description : Sequences a single-element matrix change into four element
//               SRAM banks. Maps (X, Y) to bank/row, writes the 48-bit element
//               as a hi word then a lo word, and flags completion on EOC_Flag.
// Revision    : 1.0 - initial release
// ============================================================================
module change_update_ctrl #(
    parameter int NCOLS      = 20,
    parameter int NROWS      = 25,
    parameter int BANK_DEPTH = 250,
    parameter int DW         = 24
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            EnableChange,
    input  logic [15:0]     X,
    input  logic [15:0]     Y,
    input  logic [2*DW-1:0] NewElement,
    output logic            EOC_Flag,
    output logic [1:0]      mem_bank,
    output logic [7:0]      mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic            mem_we,
    output logic            range_err,
    output logic [15:0]     change_count
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CALC  = 3'd1;
    localparam logic [2:0] c_CHECK = 3'd2;
    localparam logic [2:0] c_WR_HI = 3'd3;
    localparam logic [2:0] c_WR_LO = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;

    logic [2:0]      r_state;
    logic            r_armed;
    logic [15:0]     r_x;
    logic [15:0]     r_y;
    logic [2*DW-1:0] r_elem;
    logic [1:0]      r_bank;
    logic [29:0]     r_row;

    logic            r_eoc;
    logic [1:0]      r_mem_bank;
    logic [7:0]      r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_mem_we;
    logic            r_range_err;
    logic [15:0]     r_count;

    logic            w_accept;
    logic [31:0]     w_idx;
    logic            w_in_range;
    logic [7:0]      w_addr_base;

    // Request acceptance, element index and range decode
    always_comb begin
        w_accept    = ((r_state == c_IDLE) || (r_state == c_DONE)) && EnableChange && r_armed;
        // Full 32-bit product so large X/Y can never alias into a valid row
        w_idx       = ({16'd0, r_x} * 32'(NCOLS)) + {16'd0, r_y};
        w_in_range  = (r_x < 16'(NROWS)) && (r_y < 16'(NCOLS)) &&
                      ({r_row, 1'b1} < 31'(BANK_DEPTH));
        w_addr_base = {r_row[6:0], 1'b0};
    end

    // Control FSM, operand latches, arming and change counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_armed     <= 1'b1;
            r_x         <= '0;
            r_y         <= '0;
            r_elem      <= '0;
            r_bank      <= '0;
            r_row       <= '0;
            r_range_err <= 1'b0;
            r_count     <= '0;
        end else begin
            // A low sample re-arms; acceptance below disarms until the next low
            if (!EnableChange) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                c_CALC: begin
                    r_bank  <= w_idx[1:0];
                    r_row   <= w_idx[31:2];
                    r_state <= c_CHECK;
                end
                c_CHECK: begin
                    if (w_in_range) begin
                        r_state <= c_WR_HI;
                    end else begin
                        r_range_err <= 1'b1;
                        r_state     <= c_DONE;
                    end
                end
                c_WR_HI: r_state <= c_WR_LO;
                c_WR_LO: begin
                    r_count <= r_count + 16'd1;
                    r_state <= c_DONE;
                end
                default: begin
                    if (w_accept) begin
                        r_x         <= X;
                        r_y         <= Y;
                        r_elem      <= NewElement;
                        r_armed     <= 1'b0;
                        r_range_err <= 1'b0;
                        r_state     <= c_CALC;
                    end
                end
            endcase
        end
    end

    // Registered bank write port and completion flag, decoded from state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_eoc       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_bank  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_eoc       <= (r_state == c_DONE) && !w_accept;
            r_mem_we    <= 1'b0;
            r_mem_bank  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            if (r_state == c_WR_HI) begin
                r_mem_we    <= 1'b1;
                r_mem_bank  <= r_bank;
                r_mem_addr  <= w_addr_base;
                r_mem_wdata <= r_elem[2*DW-1:DW];
            end else if (r_state == c_WR_LO) begin
                r_mem_we    <= 1'b1;
                r_mem_bank  <= r_bank;
                r_mem_addr  <= w_addr_base | 8'd1;
                r_mem_wdata <= r_elem[DW-1:0];
            end
        end
    end

    assign EOC_Flag     = r_eoc;
    assign mem_bank     = r_mem_bank;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_we       = r_mem_we;
    assign range_err    = r_range_err;
    assign change_count = r_count;

endmodule
`default_nettype wire
